axi_stream_burst_writer: RTL

AXI_STREAM_BURST_WRITER -- requirements
Module: axi_stream_burst_writer

---
 rtl/axi_stream_burst_writer_pkg.sv | 30 +++
 rtl/axi_stream_burst_writer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/axi_stream_burst_writer_pkg.sv
// Shared types and constants for the AXI-Stream to AXI4 burst writer.
// Burst sizing lives here so the page-boundary rule has a single home.
package axi_stream_burst_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [2:0] SIZE_64    = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES = 4096;

  // Beats for the next burst: bounded by what is left, the burst cap and the 4 KB page end.
  function automatic logic [8:0] burst_len(input logic [15:0] remaining,
                                           input logic [11:0] page_off,
                                           input logic [8:0]  max_len);
    logic [15:0] page_beats;
    logic [15:0] len;
    page_beats = 16'((13'(PAGE_BYTES) - {1'b0, page_off}) >> 3);
    len        = {7'd0, max_len};
    if (page_beats < len) len = page_beats;
    if (remaining < len)  len = remaining;
    return len[8:0];
  endfunction

endpackage

// File: rtl/axi_stream_burst_writer.sv
// Writes a stream of 64-bit beats to memory as AXI4 INCR bursts, one burst in flight,
// splitting commands at the burst cap and at every 4 KB page boundary.
module axi_stream_burst_writer
  import axi_stream_burst_writer_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_BURST_LEN  = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [15:0]                     CMD_BEATS,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  output logic                            DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
  logic [15:0]                     remaining;
  logic [7:0]                      beat_cnt;
  logic                            done_r;
  logic                            error_r;
  logic [8:0]                      len;
  logic                            w_hs;
  logic                            last_beat;

  // addr/remaining only move in RESP, so the AW fields derived from them stay put in ADDR.
  assign len       = burst_len(remaining, addr[11:0], 9'(C_M_AXI_BURST_LEN));
  assign last_beat = ({1'b0, beat_cnt} == (len - 9'd1));
  assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;

  assign CMD_READY     = (state == ST_IDLE);
  assign M_AXI_AWVALID = (state == ST_ADDR);
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = 8'(len - 9'd1);
  assign M_AXI_AWSIZE  = SIZE_64;
  assign M_AXI_AWBURST = BURST_INCR;

  assign M_AXI_WVALID  = (state == ST_DATA) && S_AXIS_TVALID;
  assign S_AXIS_TREADY = (state == ST_DATA) && M_AXI_WREADY;
  assign M_AXI_WDATA   = S_AXIS_TDATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (state == ST_DATA) && last_beat;
  assign M_AXI_BREADY  = (state == ST_RESP);

  assign DONE  = done_r;
  assign ERROR = error_r;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CMD_VALID) begin
            error_r   <= 1'b0;
            addr      <= CMD_ADDR & ~C_M_AXI_ADDR_WIDTH'(7);
            remaining <= CMD_BEATS;
            beat_cnt  <= '0;
            if (CMD_BEATS == 16'd0) done_r <= 1'b1;
            else                    state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_AWREADY) state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_RESP: begin
          // A bad response is recorded but the remaining bursts still go out.
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != RESP_OKAY) error_r <= 1'b1;
            addr      <= addr + C_M_AXI_ADDR_WIDTH'({len, 3'b000});
            remaining <= remaining - 16'(len);
            if (remaining == 16'(len)) begin
              done_r <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              state  <= ST_ADDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
